// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder slice: FSM state encoding
//   (legacy two-bit constants) and the default operand width.
//   Optional feature macro: SERIAL_ADDER_OVF_EN (signed overflow flag).
package serial_adder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    localparam int unsigned WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if
//   Operand/result handshake bundle for serial_adder_ctrl.
//   Signals:
//     in_valid/in_ready   operand pair handshake (a, b, cin)
//     out_valid/out_ready result handshake (sum, cout, ovf)
//     busy                controller is shifting bits
//   Modports: master = operand producer / result consumer, slave = controller.
interface serial_adder_ctrl_if
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );

endinterface

// File: rtl/serial_adder_ctrl_bit_full_adder.sv
// half_adder / bit_full_adder
//   One-bit full-adder slice used by serial_adder_ctrl, built from two
//   half adders and an OR of their carries.
//   half_adder ports:     x, y -> s (sum), c (carry)
//   bit_full_adder ports: a, b, ci -> s (sum), co (carry out)
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module bit_full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha0 (.x(a),  .y(b),  .s(s1), .c(c1));
    half_adder u_ha1 (.x(s1), .y(ci), .s(s),  .c(c2));

    assign co = c1 | c2;
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial adder: {cout,sum} = a + b + cin, LSB first, one bit per clock
//   through a single bit_full_adder slice.
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous, active-high reset
//     bus  - serial_adder_ctrl_if.slave (in_valid/in_ready, a, b, cin,
//            out_valid/out_ready, sum, cout, ovf, busy)
//   Optional macro SERIAL_ADDER_OVF_EN: when defined, ovf is the signed
//   overflow of the addition; otherwise ovf is tied low.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_ctrl_if.slave  bus
);

    localparam int unsigned    CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  DONE_CNT = CW'(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             fa_s;
    logic             fa_co;

    bit_full_adder u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // RUN lasts WIDTH+1 cycles: counts 0..WIDTH-1 each add one bit, the
    // count==WIDTH cycle publishes the result, so out_valid rises WIDTH+1
    // cycles after the accepting edge and the counter stops without wrapping.
    // Results live in separate output registers so sum/cout hold their last
    // values while a new operation is shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh  <= bus.a;
                        b_sh  <= bus.b;
                        carry <= bus.cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (cnt == DONE_CNT) begin
                        sum_q  <= res_sh;
                        cout_q <= carry;
                        state  <= DONE;
                    end else begin
                        res_sh <= {fa_s, res_sh[WIDTH-1:1]};
                        a_sh   <= a_sh >> 1;
                        b_sh   <= b_sh >> 1;
                        carry  <= fa_co;
                        cnt    <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // Carry into the MSB is the carry register while the MSB is being added;
    // it is compared with the final carry when the result is published.
    logic msb_cin;
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            msb_cin <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state == RUN) begin
            if (cnt == LAST_BIT) begin
                msb_cin <= carry;
            end
            if (cnt == DONE_CNT) begin
                ovf_q <= msb_cin ^ carry;
            end
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state == RUN);
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl
//   Directed self-checking bench for serial_adder_ctrl at WIDTH=8.
//   Expected ovf depends on SERIAL_ADDER_OVF_EN being defined for the build.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

`ifdef SERIAL_ADDER_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk;
    logic rst;

    int n_checks;
    int n_fails;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer an operand pair at a negedge; returns #1 after the accepting edge.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
        @(negedge clk);
        check("in_ready_before_accept", {31'b0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.a        = ta;
        bus.b        = tb_v;
        bus.cin      = tc;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        bus.cin      = 1'b1;
        check("busy_after_accept", {31'b0, bus.busy}, 32'd1);
        check("in_ready_in_run", {31'b0, bus.in_ready}, 32'd0);
    endtask

    // Counts edges from the accept until out_valid, with a cycle budget.
    task automatic wait_done(input logic [W-1:0] es, input logic ec, input logic eo);
        int n;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 32'(n), 32'(W + 1));
        check("sum", 32'(bus.sum), 32'(es));
        check("cout", {31'b0, bus.cout}, {31'b0, ec});
        check("ovf", {31'b0, bus.ovf}, {31'b0, eo & OVF_EN});
        check("busy_in_done", {31'b0, bus.busy}, 32'd0);
    endtask

    task automatic handoff();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("out_valid_after_handoff", {31'b0, bus.out_valid}, 32'd0);
        check("in_ready_after_handoff", {31'b0, bus.in_ready}, 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        start_op(ta, tb_v, tc);
        wait_done(es, ec, eo);
        handoff();
    endtask

    initial begin
        logic [W-1:0] held;
        n_checks      = 0;
        n_fails       = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;

        // Reset with in_valid asserted: reset wins.
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = 8'h11;
        @(posedge clk);
        #1;
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", {31'b0, bus.cout}, 32'd0);
        check("rst_ovf", {31'b0, bus.ovf}, 32'd0);

        // Directed vectors, back-to-back after each handoff.
        run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op(8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1);
        run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

        // Hold in DONE for 5 cycles with in_valid pulses that must be ignored.
        start_op(8'hA5, 8'h3C, 1'b1);
        wait_done(8'hE2, 1'b0, 1'b0);
        held = bus.sum;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = i[0];
            bus.a        = 8'h01;
            bus.b        = 8'h01;
            @(posedge clk);
            #1;
            check("hold_out_valid", {31'b0, bus.out_valid}, 32'd1);
            check("hold_sum", 32'(bus.sum), 32'(held));
            check("hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
        end
        bus.in_valid = 1'b0;
        handoff();

        // Result registers keep the last value while the next op shifts.
        start_op(8'h55, 8'h22, 1'b0);
        check("sum_held_in_run", 32'(bus.sum), 32'h0000_00E2);
        // Reset on the 4th RUN cycle.
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrun_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("midrun_rst_busy", {31'b0, bus.busy}, 32'd0);
        check("midrun_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("midrun_rst_sum", 32'(bus.sum), 32'd0);
        @(posedge clk);
        #1;
        check("midrun_rst_stays_idle", {31'b0, bus.busy}, 32'd0);
        run_op(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);

        // Reset while waiting in DONE with out_ready low.
        start_op(8'h01, 8'h01, 1'b0);
        wait_done(8'h02, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("done_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("done_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("done_rst_sum", 32'(bus.sum), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operand pair offered.
REQ-005 SHALL have port in_ready  output  1  controller can accept operands.
REQ-006 SHALL have ports a, b  input  WIDTH  operands (unsigned; two's complement for overflow).
REQ-007 SHALL have port cin  input  1  carry-in, sampled with operands.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have port sum  output  WIDTH  result bits.
REQ-011 SHALL have port cout  output  1  final carry-out.
REQ-012 SHALL have port ovf  output  1  signed overflow flag (see Configuration).
REQ-013 SHALL have port busy  output  1  high while in RUN.

Function
REQ-014 SHALL compute {cout,sum} = a + b + cin bit-serially, LSB first, one bit per clock, through a single one-bit full-adder slice.
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 IDLE: in_ready=1; on in_valid&in_ready, latch a, b, cin into shift/carry registers, clear bit counter, go to RUN.
REQ-017 RUN: each cycle add the operand LSBs with the carry register, shift the sum bit into the result register MSB end, update carry, increment counter; after the WIDTH-th bit go to DONE.
REQ-018 Latency: out_valid SHALL rise exactly WIDTH+1 cycles after the accepting edge.
REQ-019 DONE: out_valid=1; sum, cout, ovf stable; on out_ready go to IDLE in the next cycle.
REQ-020 in_ready SHALL be 0 in RUN and DONE; in_valid there SHALL be ignored (no queuing).
REQ-021 out_valid low SHALL keep sum/cout/ovf at their last-computed values; back-to-back: accept in IDLE on the cycle after handoff.
REQ-022 Bit counter SHALL be ceil(log2(WIDTH+1)) bits and SHALL NOT wrap during RUN.
REQ-023 Operand inputs SHALL be ignored outside the accepting edge.

Reset
REQ-024 rst at any edge, including mid-RUN or DONE, SHALL force IDLE, discard the operation, clear counter and carry registers.
REQ-025 Reset values SHALL be: in_ready=1 in the cycle after reset; out_valid=0, busy=0, sum=0, cout=0, ovf=0.
REQ-026 rst SHALL take priority over in_valid and out_ready on the same edge.

Configuration
REQ-027 Macro SERIAL_ADDER_OVF_EN SHALL, when defined, drive ovf = carry into MSB XOR carry out of MSB, captured on the last RUN cycle.
REQ-028 Without SERIAL_ADDER_OVF_EN, port ovf SHALL remain present and tied to 0; no extra registers.

Structure
REQ-029 Package serial_adder_pkg SHALL hold the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH default.
REQ-030 The one-bit slice SHALL be a sub-module bit_full_adder built from two existing half_adder instances plus an OR of their carries.
REQ-031 All sequencing, shift registers and handshake logic SHALL stay in serial_adder_ctrl.

Verification (WIDTH=8)
REQ-032 a=0x0F, b=0x01, cin=0 -> sum=0x10, cout=0, out_valid exactly 9 cycles after accept.
REQ-033 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-034 out_ready held 0 for 5 cycles in DONE -> out_valid stays 1, sum constant; in_valid pulses ignored; IDLE one cycle after out_ready=1.
REQ-035 rst asserted on 4th RUN cycle -> next cycle IDLE, out_valid=0, busy=0; new operation 0x03+0x04 then gives 0x07.
REQ-036 With SERIAL_ADDER_OVF_EN: 0x7F+0x01 -> ovf=1; 0x80+0xFF -> ovf=1, cout=1; 0x10+0x20 -> ovf=0; without macro ovf=0 always.
